// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // Bits in one frame as seen by the 11-bit shift register.
    localparam int FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } tx_state_t;

    // XOR of the data bits (7 or 8 of them), inverted for odd sense.
    function automatic logic uart_parity(input logic [7:0] data,
                                         input logic       eight,
                                         input logic       ohel);
        logic p;
        p = eight ? (^data) : (^data[6:0]);
        return p ^ ohel;
    endfunction

endpackage

// File: rtl/uart_tx_controller_baud_tick_gen.sv
// Baud divisor: one-cycle tick every latched baud_k cycles while enabled (0 acts as 1).
// Latency: first tick baud_k cycles after the clear cycle.
// Backpressure: none; free-running while en_i is high.
module baud_tick_gen #(
    parameter int BAUD_W = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              latch_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [BAUD_W-1:0] baud_k_i,
    output logic              tick_o
);

    localparam logic [BAUD_W-1:0] ONE = BAUD_W'(1);

    logic [BAUD_W-1:0] k_q;
    logic [BAUD_W-1:0] cnt_q;
    logic [BAUD_W-1:0] cnt_d;
    logic [BAUD_W-1:0] term;

    // A divisor of zero behaves like one: terminal count is 0 either way.
    assign term   = (k_q == '0) ? '0 : (k_q - ONE);
    assign tick_o = en_i && (cnt_q == term);

    // Next count: restart on clear or on every tick, otherwise advance while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Divisor is captured once per frame so host changes cannot disturb a frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q   <= '0;
            cnt_q <= '0;
        end else begin
            if (latch_i) begin
                k_q <= baud_k_i;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_controller.sv
// Sequences load/shift strobes for the 11-bit UART TX shift register and formats frame bits.
// Latency: ld the cycle after accept; tx_done 11*baud_k+1 cycles after ld.
// Backpressure: tx_ready low for the whole frame; writes while busy are dropped.
module uart_tx_controller
    import uart_pkg::*;
#(
    parameter int BAUD_W = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BAUD_W-1:0] baud_k,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    input  logic [7:0]        tx_data,
    input  logic              tx_write,
    output logic              tx_ready,
    output logic              tx_done,
    output logic              ld,
    output logic              sh,
    output logic              bit_10,
    output logic              bit_9,
    output logic              bit_1,
    output logic              bit_0,
    output logic [6:0]        data_out
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    tx_state_t  state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] data_q;
    logic       eight_q, pen_q, ohel_q;
    logic       accept;
    logic       tick;

    assign accept = (state_q == ST_IDLE) && tx_write;

    baud_tick_gen #(
        .BAUD_W (BAUD_W)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .latch_i  (accept),
        .clr_i    (ld),
        .en_i     (state_q == ST_SHIFT),
        .baud_k_i (baud_k),
        .tick_o   (tick)
    );

    assign sh = tick;

    // FSM next state and the strobes that are pure functions of state.
    always_comb begin
        state_d  = state_q;
        tx_ready = 1'b0;
        ld       = 1'b0;
        tx_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_ready = 1'b1;
                if (tx_write) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                ld      = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tick && (bit_cnt_q == LAST_BIT)) state_d = ST_DONE;
            end
            ST_DONE: begin
                tx_done = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bit counter: restart at load, one step per shift strobe.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (ld) begin
            bit_cnt_d = '0;
        end else if (sh) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
        end
    end

    // State, bit count and the per-frame configuration snapshot taken at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            data_q    <= '0;
            eight_q   <= 1'b0;
            pen_q     <= 1'b0;
            ohel_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            if (accept) begin
                data_q  <= tx_data;
                eight_q <= eight;
                pen_q   <= pen;
                ohel_q  <= ohel;
            end
        end
    end

    // Frame formatting: bits 9/10 carry data[7], parity or stop marks by word length.
    always_comb begin
        bit_0    = 1'b1;
        bit_1    = 1'b0;
        bit_9    = 1'b1;
        bit_10   = 1'b1;
        data_out = data_q[6:0];
        case ({eight_q, pen_q})
            2'b01:   bit_9 = uart_parity(data_q, 1'b0, ohel_q);
            2'b10:   bit_9 = data_q[7];
            2'b11: begin
                bit_9  = data_q[7];
                bit_10 = uart_parity(data_q, 1'b1, ohel_q);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Self-checking bench for uart_tx_controller: cycle model plus directed frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_controller;

    localparam int BW = 19;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [BW-1:0] baud_k;
    logic          eight, pen, ohel;
    logic [7:0]    tx_data;
    logic          tx_write;
    logic          tx_ready, tx_done, ld, sh;
    logic          bit_10, bit_9, bit_1, bit_0;
    logic [6:0]    data_out;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    uart_tx_controller #(.BAUD_W(BW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_k   (baud_k),
        .eight    (eight),
        .pen      (pen),
        .ohel     (ohel),
        .tx_data  (tx_data),
        .tx_write (tx_write),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .ld       (ld),
        .sh       (sh),
        .bit_10   (bit_10),
        .bit_9    (bit_9),
        .bit_1    (bit_1),
        .bit_0    (bit_0),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_t: cycles since the accept edge (1 = load cycle), -1 when idle.
    int         m_t = -1;
    int         m_k = 1;
    logic [7:0] m_d = 8'h00;
    logic       m_e = 1'b0, m_p = 1'b0, m_o = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = -1; m_k = 1; m_d = 8'h00; m_e = 1'b0; m_p = 1'b0; m_o = 1'b0;
        end else if (m_t < 0) begin
            if (tx_write === 1'b1) begin
                m_t = 1;
                m_k = (baud_k == '0) ? 1 : int'(baud_k);
                m_d = tx_data; m_e = eight; m_p = pen; m_o = ohel;
            end
        end else if (m_t >= 11 * m_k + 2) begin
            m_t = -1;
        end else begin
            m_t++;
        end
    end

    // Shift strobes fall at k, 2k, ... 11k cycles after the load cycle.
    function automatic int exp_sh(input int t, input int k);
        return (t >= 2 && t <= 11 * k + 1 && ((t - 1) % k) == 0) ? 1 : 0;
    endfunction

    function automatic int exp_b9(input logic [7:0] d, input logic e, input logic p, input logic o);
        if (!e && p) return int'((^d[6:0]) ^ o);
        if (e)       return int'(d[7]);
        return 1;
    endfunction

    function automatic int exp_b10(input logic [7:0] d, input logic e, input logic p, input logic o);
        if (e && p) return int'((^d) ^ o);
        return 1;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("tx_ready", int'(tx_ready), (m_t < 0) ? 1 : 0);
            chk("ld",       int'(ld),       (m_t == 1) ? 1 : 0);
            chk("sh",       int'(sh),       exp_sh(m_t, m_k));
            chk("tx_done",  int'(tx_done),  (m_t == 11 * m_k + 2) ? 1 : 0);
            chk("bit_0",    int'(bit_0),    1);
            chk("bit_1",    int'(bit_1),    0);
            chk("bit_9",    int'(bit_9),    exp_b9(m_d, m_e, m_p, m_o));
            chk("bit_10",   int'(bit_10),   exp_b10(m_d, m_e, m_p, m_o));
            chk("data_out", int'(data_out), int'(m_d[6:0]));
        end
    end

    // ---------------- directed frame driver ----------------
    // Offsets count cycles from the accept cycle (offset 0).
    task automatic run_frame(input logic [7:0] d, input int k, input logic e, input logic p,
                             input logic o, input int poke_a, input int poke_b, input bit scramble,
                             output int ld_off, output int n_sh, output int first_sh,
                             output int last_sh, output int done_off, output int ready_off,
                             output int n_done, output logic [3:0] fb, output logic [6:0] dout);
        int off;
        int keff;
        bit done_seen;
        keff = (k == 0) ? 1 : k;
        ld_off = -1; n_sh = 0; first_sh = -1; last_sh = -1;
        done_off = -1; ready_off = -1; n_done = 0; fb = 4'h0; dout = 7'h00;
        done_seen = 1'b0;
        @(posedge clk); #2;
        tx_data = d; baud_k = k[BW-1:0]; eight = e; pen = p; ohel = o; tx_write = 1'b1;
        @(posedge clk); #2;
        tx_write = 1'b0;
        off = 1;
        while (off < 11 * keff + 20) begin
            @(negedge clk);
            if (ld) begin
                if (ld_off < 0) ld_off = off;
                fb   = {bit_10, bit_9, bit_1, bit_0};
                dout = data_out;
            end
            if (sh) begin
                n_sh++;
                if (first_sh < 0) first_sh = off;
                last_sh = off;
            end
            if (tx_done) begin
                n_done++;
                if (done_off < 0) done_off = off;
                done_seen = 1'b1;
            end
            if (done_seen && tx_ready) begin
                ready_off = off;
                break;
            end
            @(posedge clk); #2;
            off++;
            tx_write = (off == poke_a || off == poke_b);
            if (scramble && tx_write) begin
                baud_k  = BW'($urandom_range(1, 9));
                eight   = ~eight;
                tx_data = ~tx_data;
            end
        end
        tx_write = 1'b0;
        if (ready_off < 0) chk("frame_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int ld_off, n_sh, first_sh, last_sh, done_off, ready_off, n_done, cnt;
        logic [3:0] fb;
        logic [6:0] dout;

        rst_n = 1'b1; baud_k = '0; eight = 1'b0; pen = 1'b0; ohel = 1'b0;
        tx_data = 8'h00; tx_write = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_tx_ready", int'(tx_ready), 1);
        chk("rst_tx_done",  int'(tx_done),  0);
        chk("rst_ld",       int'(ld),       0);
        chk("rst_sh",       int'(sh),       0);
        chk("rst_bits",     int'({bit_10, bit_9, bit_1, bit_0}), 'b1101);
        chk("rst_data_out", int'(data_out), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        chk_on = 1'b1;

        // Basic 8N frame, divisor 4.
        run_frame(8'hA5, 4, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0,
                  ld_off, n_sh, first_sh, last_sh, done_off, ready_off, n_done, fb, dout);
        chk("a5_ld_off",   ld_off,    1);
        chk("a5_bits",     int'(fb),  'b1101);
        chk("a5_data_out", int'(dout), 'h25);
        chk("a5_n_sh",     n_sh,      11);
        chk("a5_first_sh", first_sh,  5);
        chk("a5_last_sh",  last_sh,   45);
        chk("a5_done",     done_off,  46);
        chk("a5_ready",    ready_off, 47);
        chk("a5_n_done",   n_done,    1);

        // Parity matrix on 0x83: low seven bits hold two ones, all eight hold three.
        run_frame(8'h83, 1, 1'b0, 1'b1, 1'b0, -1, -1, 1'b0,
                  ld_off, n_sh, first_sh, last_sh, done_off, ready_off, n_done, fb, dout);
        chk("par7_even_b9", int'(fb[2]), 0);
        chk("par7_even_b10", int'(fb[3]), 1);
        chk("par7_done",    done_off,    13);
        run_frame(8'h83, 1, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0,
                  ld_off, n_sh, first_sh, last_sh, done_off, ready_off, n_done, fb, dout);
        chk("par7_odd_b9",  int'(fb[2]), 1);
        run_frame(8'h83, 1, 1'b1, 1'b1, 1'b0, -1, -1, 1'b0,
                  ld_off, n_sh, first_sh, last_sh, done_off, ready_off, n_done, fb, dout);
        chk("par8_even_b9",  int'(fb[2]), 1);
        chk("par8_even_b10", int'(fb[3]), 1);
        chk("par8_data_out", int'(dout),  'h03);

        // Writes mid-frame and in the DONE cycle (offset 24 for divisor 2) are dropped.
        run_frame(8'h3C, 2, 1'b0, 1'b0, 1'b0, 10, 24, 1'b0,
                  ld_off, n_sh, first_sh, last_sh, done_off, ready_off, n_done, fb, dout);
        chk("ign_done",   done_off,  24);
        chk("ign_ready",  ready_off, 25);
        chk("ign_n_done", n_done,    1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ld) cnt++;
        end
        chk("ign_no_extra_ld", cnt, 0);

        // Divisor 0 behaves as 1.
        run_frame(8'h11, 0, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0,
                  ld_off, n_sh, first_sh, last_sh, done_off, ready_off, n_done, fb, dout);
        chk("k0_first_sh", first_sh, 2);
        chk("k0_last_sh",  last_sh,  12);
        chk("k0_n_sh",     n_sh,     11);
        chk("k0_done",     done_off, 13);

        // Inputs scrambled mid-frame must not disturb timing or frame bits.
        run_frame(8'h5A, 3, 1'b1, 1'b1, 1'b1, 10, 20, 1'b1,
                  ld_off, n_sh, first_sh, last_sh, done_off, ready_off, n_done, fb, dout);
        chk("scr_bits",     int'(fb),   'b1001);
        chk("scr_data_out", int'(dout), 'h5A);
        chk("scr_first_sh", first_sh,   4);
        chk("scr_n_sh",     n_sh,       11);
        chk("scr_done",     done_off,   35);

        // Reset after the 5th shift aborts the frame.
        @(posedge clk); #2;
        tx_data = 8'hC3; baud_k = BW'(2); eight = 1'b1; pen = 1'b1; ohel = 1'b0; tx_write = 1'b1;
        @(posedge clk); #2;
        tx_write = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 5; i++) begin
            @(negedge clk);
            if (sh) cnt++;
        end
        chk("rst_mid_sh_seen", cnt, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx_ready", int'(tx_ready), 1);
        chk("abort_tx_done",  int'(tx_done),  0);
        chk("abort_ld",       int'(ld),       0);
        chk("abort_sh",       int'(sh),       0);
        chk("abort_bits",     int'({bit_10, bit_9, bit_1, bit_0}), 'b1101);
        chk("abort_data_out", int'(data_out), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        run_frame(8'h3C, 2, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0,
                  ld_off, n_sh, first_sh, last_sh, done_off, ready_off, n_done, fb, dout);
        chk("post_rst_done",   done_off, 24);
        chk("post_rst_n_done", n_done,   1);
        chk("post_rst_n_sh",   n_sh,     11);

        repeat (3) @(negedge clk);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
